// File: rtl/spi_master_cfg.sv
// SPI master with a divided sclk, all four CPOL/CPHA modes, selectable bit order
// and a configurable word width.
module spi_master_cfg #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  lsb_first,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic                  cs_n
);
    localparam int EDGES  = 2 * DATA_WIDTH;
    localparam int DIV_W  = $clog2(CLK_DIV + 1);
    localparam int EDGE_W = $clog2(EDGES + 1);

    typedef enum logic [1:0] {IDLE, SETUP, TRANSFER, HOLD} state_t;

    state_t                  state;
    logic [DIV_W-1:0]        div_cnt;
    logic [EDGE_W-1:0]       edge_cnt;
    logic [DATA_WIDTH-1:0]   tx_sh;
    logic [DATA_WIDTH-1:0]   rx_sh;
    logic                    cpha_q;
    logic                    lsb_q;

    logic [DATA_WIDTH-1:0]   tx_ord;
    logic                    div_done;
    logic                    sample;
    logic                    last_edge;

    function automatic logic [DATA_WIDTH-1:0] rev(input logic [DATA_WIDTH-1:0] v);
        logic [DATA_WIDTH-1:0] r;
        for (int i = 0; i < DATA_WIDTH; i++) r[i] = v[DATA_WIDTH-1-i];
        return r;
    endfunction

    // Both shift registers always work MSB-side; LSB-first is handled by mirroring
    // the word on the way in and on the way out.
    always_comb begin
        tx_ord    = lsb_first ? rev(tx_data) : tx_data;
        div_done  = (div_cnt == DIV_W'(CLK_DIV - 1));
        sample    = ~edge_cnt[0] ^ cpha_q;
        last_edge = (edge_cnt == EDGE_W'(EDGES - 1));
    end

    assign tx_ready = (state == IDLE) && !rst;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cs_n     <= 1'b1;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            div_cnt  <= '0;
            edge_cnt <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            cpha_q   <= 1'b0;
            lsb_q    <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    sclk     <= cpol;
                    mosi     <= 1'b0;
                    cs_n     <= 1'b1;
                    div_cnt  <= '0;
                    edge_cnt <= '0;
                    if (tx_valid) begin
                        state  <= SETUP;
                        cs_n   <= 1'b0;
                        cpha_q <= cpha;
                        lsb_q  <= lsb_first;
                        // cpha=0 needs the first bit on the wire before the first edge
                        if (!cpha) begin
                            mosi  <= tx_ord[DATA_WIDTH-1];
                            tx_sh <= {tx_ord[DATA_WIDTH-2:0], 1'b0};
                        end else begin
                            tx_sh <= tx_ord;
                        end
                    end
                end
                SETUP: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        state   <= TRANSFER;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                TRANSFER: begin
                    if (div_done) begin
                        div_cnt  <= '0;
                        sclk     <= ~sclk;
                        edge_cnt <= edge_cnt + 1'b1;
                        if (sample) begin
                            rx_sh <= {rx_sh[DATA_WIDTH-2:0], miso};
                        end else if (!last_edge) begin
                            mosi  <= tx_sh[DATA_WIDTH-1];
                            tx_sh <= tx_sh << 1;
                        end
                        if (last_edge) begin
                            state    <= HOLD;
                            edge_cnt <= '0;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (div_done) begin
                        div_cnt  <= '0;
                        state    <= IDLE;
                        cs_n     <= 1'b1;
                        rx_valid <= 1'b1;
                        rx_data  <= lsb_q ? rev(rx_sh) : rx_sh;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_cfg.sv
// Directed bench for spi_master_cfg: an 8-bit/div-2 instance and a 16-bit/div-1 instance.
module tb_spi_master_cfg;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;

    logic [7:0]  a_tx_data = '0;
    logic        a_tx_valid = 1'b0;
    logic        a_tx_ready, a_rx_valid, a_busy, a_sclk, a_mosi, a_miso, a_cs_n;
    logic [7:0]  a_rx_data;

    logic [15:0] b_tx_data = '0;
    logic        b_tx_valid = 1'b0;
    logic        b_tx_ready, b_rx_valid, b_busy, b_sclk, b_mosi, b_miso, b_cs_n;
    logic [15:0] b_rx_data;

    logic        slave_en = 1'b0;
    logic        slave_bit = 1'b0;
    logic [7:0]  slave_word = '0;
    int          slave_base = 0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign a_miso = slave_en ? slave_bit : a_mosi;
    assign b_miso = b_mosi;

    spi_master_cfg #(.DATA_WIDTH(8), .CLK_DIV(2)) dut_a (
        .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
        .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
        .rx_data(a_rx_data), .rx_valid(a_rx_valid), .busy(a_busy),
        .sclk(a_sclk), .mosi(a_mosi), .miso(a_miso), .cs_n(a_cs_n));

    spi_master_cfg #(.DATA_WIDTH(16), .CLK_DIV(1)) dut_b (
        .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
        .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
        .rx_data(b_rx_data), .rx_valid(b_rx_valid), .busy(b_busy),
        .sclk(b_sclk), .mosi(b_mosi), .miso(b_miso), .cs_n(b_cs_n));

    // Monitor counters are monotonic; the stimulus only reads them as deltas.
    int a_cs_cyc = 0, a_win_len = 0, a_wins = 0, a_gap = 1, a_gap_viol = 0;
    int a_rise = 0, a_fall = 0, a_rxv = 0, a_rdy_viol = 0, a_mosi_viol = 0, a_mosi_hi = 0;
    logic [7:0] a_rx_log [16];
    logic a_ps = 1'b0, a_pm = 1'b0, a_pc = 1'b1;

    always @(negedge clk) begin
        if (!a_cs_n && a_pc && a_gap < 1) a_gap_viol++;
        if (a_cs_n && !a_pc) begin
            a_win_len = a_cs_cyc;
            a_wins++;
            a_cs_cyc = 0;
            a_gap = 0;
        end
        if (a_cs_n) a_gap++;
        if (!a_cs_n) begin
            a_cs_cyc++;
            if (a_mosi) a_mosi_hi++;
        end
        if (!a_cs_n && !a_pc) begin
            if (!a_ps && a_sclk) a_rise++;
            if (a_ps && !a_sclk) begin
                a_fall++;
                // slave for cpol=1/cpha=1: present next bit on each falling (leading) edge
                if (slave_en && (a_fall - slave_base) >= 1 && (a_fall - slave_base) <= 8)
                    slave_bit = slave_word[8 - (a_fall - slave_base)];
            end
            if (a_mosi != a_pm && !(a_ps && !a_sclk)) a_mosi_viol++;
        end
        if (a_rx_valid) begin
            a_rx_log[a_rxv % 16] = a_rx_data;
            a_rxv++;
            if (!a_tx_ready) a_rdy_viol++;
        end
        a_ps = a_sclk;
        a_pm = a_mosi;
        a_pc = a_cs_n;
    end

    int b_cs_cyc = 0, b_win_len = 0, b_wins = 0, b_fall = 0;
    logic b_ps = 1'b0, b_pc = 1'b1;

    always @(negedge clk) begin
        if (b_cs_n && !b_pc) begin
            b_win_len = b_cs_cyc;
            b_wins++;
            b_cs_cyc = 0;
        end
        if (!b_cs_n) b_cs_cyc++;
        if (!b_cs_n && !b_pc && b_ps && !b_sclk) b_fall++;
        b_ps = b_sclk;
        b_pc = b_cs_n;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready_a();
        int n = 0;
        while (!a_tx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!a_tx_ready) chk("a_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic start_a(input logic [7:0] d);
        a_tx_data  = d;
        a_tx_valid = 1'b1;
        wait_ready_a();
        @(negedge clk);
        a_tx_valid = 1'b0;
    endtask

    task automatic wait_rx_a();
        int n = 0;
        while (!a_rx_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!a_rx_valid) chk("a_rx_timeout", 32'd0, 32'd1);
        repeat (4) @(negedge clk);
    endtask

    logic [7:0] words [3];
    int s_wins, s_rxv, s_rise, s_viol, s_hi, s_gap, s_rdy, s_bfall, s_bwins, nb, edges;
    logic prev_s;

    initial begin
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", a_cs_n, 1);
        chk("rst_sclk", a_sclk, 0);
        chk("rst_mosi", a_mosi, 0);
        chk("rst_rx_data", a_rx_data, 0);
        chk("rst_rx_valid", a_rx_valid, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_tx_ready", a_tx_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_tx_ready", a_tx_ready, 1);

        // mode 0, MSB first, loopback
        s_wins = a_wins; s_rxv = a_rxv; s_rise = a_rise;
        start_a(8'hA5);
        wait_rx_a();
        chk("t1_rx_data", a_rx_data, 8'hA5);
        chk("t1_rxv_pulses", a_rxv - s_rxv, 1);
        chk("t1_cs_low", a_win_len, 36);
        chk("t1_windows", a_wins - s_wins, 1);
        chk("t1_rise_edges", a_rise - s_rise, 8);
        chk("t1_sclk_idle", a_sclk, 0);

        // mode 3, slave returns 0x3C while 0xFF goes out
        cpol = 1'b1; cpha = 1'b1;
        repeat (2) @(negedge clk);
        chk("t2_sclk_idle_pre", a_sclk, 1);
        slave_word = 8'h3C; slave_base = a_fall; slave_en = 1'b1;
        s_viol = a_mosi_viol;
        start_a(8'hFF);
        wait_rx_a();
        chk("t2_rx_data", a_rx_data, 8'h3C);
        chk("t2_sclk_idle_post", a_sclk, 1);
        chk("t2_mosi_on_fall", a_mosi_viol - s_viol, 0);
        chk("t2_cs_low", a_win_len, 36);
        slave_en = 1'b0;

        // mode 1, LSB first, 0x01: mosi high only for the first bit (2*CLK_DIV cycles)
        cpol = 1'b0; cpha = 1'b1; lsb_first = 1'b1;
        repeat (2) @(negedge clk);
        s_hi = a_mosi_hi;
        start_a(8'h01);
        wait_rx_a();
        chk("t3_rx_data", a_rx_data, 8'h01);
        chk("t3_mosi_high_cycles", a_mosi_hi - s_hi, 4);

        // back-to-back with tx_valid held, mode pins wiggled mid-word
        cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
        repeat (2) @(negedge clk);
        s_wins = a_wins; s_rxv = a_rxv; s_gap = a_gap_viol; s_rdy = a_rdy_viol;
        a_tx_valid = 1'b1;
        for (int w = 0; w < 3; w++) begin
            a_tx_data = words[w];
            wait_ready_a();
            @(negedge clk);
            if (w == 2) a_tx_valid = 1'b0;
            repeat (8) @(negedge clk);
            cpol = 1'b1; cpha = 1'b1; lsb_first = 1'b1;
            repeat (8) @(negedge clk);
            cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
        end
        wait_rx_a();
        chk("t4_windows", a_wins - s_wins, 3);
        chk("t4_rxv_pulses", a_rxv - s_rxv, 3);
        chk("t4_rx0", a_rx_log[s_rxv % 16], 8'h11);
        chk("t4_rx1", a_rx_log[(s_rxv + 1) % 16], 8'h22);
        chk("t4_rx2", a_rx_log[(s_rxv + 2) % 16], 8'h33);
        chk("t4_cs_gap", a_gap_viol - s_gap, 0);
        chk("t4_ready_at_rxv", a_rdy_viol - s_rdy, 0);

        // reset in the middle of a mode 2 transfer
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t5_rx_cleared", a_rx_data, 0);
        cpol = 1'b1; cpha = 1'b0;
        repeat (2) @(negedge clk);
        s_rxv = a_rxv;
        start_a(8'h7A);
        edges = 0; nb = 0; prev_s = a_sclk;
        while (edges < 4 && nb < 200) begin
            @(negedge clk);
            if (a_sclk != prev_s) edges++;
            prev_s = a_sclk;
            nb++;
        end
        chk("t5_reached_edge4", edges, 4);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_cs_n", a_cs_n, 1);
        chk("t5_sclk", a_sclk, 0);
        chk("t5_mosi", a_mosi, 0);
        chk("t5_busy", a_busy, 0);
        chk("t5_rx_valid", a_rx_valid, 0);
        cpol = 1'b0;
        rst = 1'b0;
        repeat (60) @(negedge clk);
        chk("t5_no_rxv", a_rxv - s_rxv, 0);
        chk("t5_rx_held", a_rx_data, 0);
        start_a(8'hC3);
        wait_rx_a();
        chk("t5_fresh_rx", a_rx_data, 8'hC3);

        // 16-bit, div 1, mode 2, loopback
        cpol = 1'b1; cpha = 1'b0;
        repeat (2) @(negedge clk);
        s_bfall = b_fall; s_bwins = b_wins;
        b_tx_data = 16'hBEEF; b_tx_valid = 1'b1;
        nb = 0;
        while (!b_tx_ready && nb < 200) begin
            @(negedge clk);
            nb++;
        end
        @(negedge clk);
        b_tx_valid = 1'b0;
        nb = 0;
        while (!b_rx_valid && nb < 200) begin
            @(negedge clk);
            nb++;
        end
        chk("t6_rx_seen", b_rx_valid, 1);
        repeat (4) @(negedge clk);
        chk("t6_rx_data", b_rx_data, 16'hBEEF);
        chk("t6_cs_low", b_win_len, 34);
        chk("t6_windows", b_wins - s_bwins, 1);
        chk("t6_sample_edges", b_fall - s_bfall, 16);
        chk("t6_sclk_idle", b_sclk, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
